// File: rtl/corelet_ctrl.sv
// corelet_ctrl: per-tile instruction sequencer (kernel load, activation stream, OFIFO drain).
// Define CORELET_CTRL_ACC_EN to add the pmem accumulate pass (state ACC) after DRAIN.
module corelet_ctrl #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11,
  parameter int X_BASE  = 0,
  parameter int W_BASE  = 1024,
  parameter int P_BASE  = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [addr_bw-1:0] num_x,
  input  logic               L0_full,
  input  logic               ofifo_valid,
  output logic [33:0]        inst,
  output logic               busy,
  output logic               done
);
  localparam logic [33:0]        INST_IDLE = 34'h1_800C_0000;
  localparam logic [addr_bw-1:0] ONE       = addr_bw'(1);
  localparam logic [addr_bw-1:0] COL_C     = addr_bw'(col);
  localparam logic [addr_bw-1:0] RC_C      = addr_bw'(row + col);
  localparam logic [addr_bw-1:0] X_B       = addr_bw'(X_BASE);
  localparam logic [addr_bw-1:0] W_B       = addr_bw'(W_BASE);
  localparam logic [addr_bw-1:0] P_B       = addr_bw'(P_BASE);

  typedef enum logic [3:0] {
    S_IDLE, S_WLOAD, S_WKERN, S_WPAUSE, S_XLOAD, S_XEXEC, S_DRAIN,
`ifdef CORELET_CTRL_ACC_EN
    S_ACC,
`endif
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [addr_bw-1:0] numx_q, numx_d;
  logic [addr_bw-1:0] k_q, k_d;     // requests issued in the current phase
  logic [addr_bw-1:0] n_q, n_d;     // completions / cycles elapsed in the current phase
  logic               pend_q, pend_d;
  logic [33:0]        inst_q, inst_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic [addr_bw-1:0] tgt, xbase, a_x, a_p;
  logic               last;
  logic               f_acc, cen_p, wen_p, cen_x;
  logic               ofifo_rd, l0_rd, l0_wr, execute, load;

  always_comb begin
    state_d = state_q;
    numx_d  = numx_q;
    k_d     = k_q;
    n_d     = n_q;
    pend_d  = 1'b0;
    done_d  = 1'b0;
    f_acc = 1'b0; cen_p = 1'b1; wen_p = 1'b1; a_p = '0;
    cen_x = 1'b1; a_x = '0;
    ofifo_rd = 1'b0; l0_rd = 1'b0; l0_wr = 1'b0; execute = 1'b0; load = 1'b0;
    case (state_q)
      S_WLOAD, S_WKERN: tgt = COL_C;
      S_WPAUSE:         tgt = RC_C;
      default:          tgt = numx_q;
    endcase
    xbase = (state_q == S_WLOAD) ? W_B : X_B;
    last  = (n_q == tgt - ONE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          numx_d  = num_x;
          k_d     = '0;
          n_d     = '0;
          state_d = S_WLOAD;
        end
      end
      S_WLOAD, S_XLOAD: begin
        a_x = xbase + k_q;
        if (k_q != tgt && !L0_full) begin
          cen_x  = 1'b0;
          k_d    = k_q + ONE;
          pend_d = 1'b1;
        end
        // a read issued last cycle always lands, even if L0 is now full
        if (pend_q) begin
          l0_wr = 1'b1;
          n_d   = n_q + ONE;
          if (last) begin
            k_d     = '0;
            n_d     = '0;
            state_d = (state_q == S_WLOAD) ? S_WKERN : S_XEXEC;
          end
        end
      end
      S_WKERN: begin
        l0_rd = 1'b1;
        load  = 1'b1;
        n_d   = n_q + ONE;
        if (last) begin
          n_d     = '0;
          state_d = S_WPAUSE;
        end
      end
      S_WPAUSE: begin
        n_d = n_q + ONE;
        if (last) begin
          n_d     = '0;
          state_d = (numx_q == '0) ? S_DONE : S_XLOAD;
        end
      end
      S_XEXEC: begin
        l0_rd   = 1'b1;
        execute = 1'b1;
        n_d     = n_q + ONE;
        if (last) begin
          n_d     = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (k_q != numx_q && ofifo_valid) begin
          ofifo_rd = 1'b1;
          k_d      = k_q + ONE;
          pend_d   = 1'b1;
        end
        if (pend_q) begin
          cen_p = 1'b0;
          wen_p = 1'b0;
          a_p   = P_B + n_q;
          n_d   = n_q + ONE;
          if (last) begin
            k_d = '0;
            n_d = '0;
`ifdef CORELET_CTRL_ACC_EN
            state_d = S_ACC;
`else
            state_d = S_DONE;
`endif
          end
        end
      end
`ifdef CORELET_CTRL_ACC_EN
      S_ACC: begin
        if (k_q != numx_q) begin
          cen_p  = 1'b0;
          a_p    = P_B + k_q;
          k_d    = k_q + ONE;
          pend_d = 1'b1;
        end
        if (pend_q) begin
          f_acc = 1'b1;
          n_d   = n_q + ONE;
          if (last) begin
            k_d     = '0;
            n_d     = '0;
            state_d = S_DONE;
          end
        end
      end
`endif
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    inst_d = {f_acc, cen_p, wen_p, 11'(a_p), cen_x, 1'b1, 11'(a_x),
              ofifo_rd, 1'b0, 1'b0, l0_rd, l0_wr, execute, load};
    // keep busy through the DONE cycle so it drops together with done
    busy_d = (state_q != S_IDLE) || (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      numx_q  <= '0;
      k_q     <= '0;
      n_q     <= '0;
      pend_q  <= 1'b0;
      inst_q  <= INST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      numx_q  <= numx_d;
      k_q     <= k_d;
      n_q     <= n_d;
      pend_q  <= pend_d;
      inst_q  <= inst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_corelet_ctrl.sv
// Scoreboard bench for corelet_ctrl: stimulus pushes expected transactions, a monitor pops and checks.
`timescale 1ns/1ps
module tb_corelet_ctrl;
  localparam int ROW = 8, COL = 8, ABW = 11, XB = 0, WB = 1024, PB = 0;
  localparam int AMOD = 1 << ABW;
  localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;

  logic           clk = 1'b0;
  logic           reset, start;
  logic [ABW-1:0] num_x;
  logic           L0_full, ofifo_valid;
  logic [33:0]    inst;
  logic           busy, done;

  logic full_dir = 1'b0, full_rnd = 1'b0, stall_rand = 1'b0;
  logic ofv_rnd = 1'b1, ofifo_rand = 1'b0;
  logic full_s = 1'b0, ofv_s = 1'b0;
  assign L0_full     = stall_rand ? full_rnd : full_dir;
  assign ofifo_valid = ofifo_rand ? ofv_rnd : 1'b1;

  corelet_ctrl #(.row(ROW), .col(COL), .addr_bw(ABW), .X_BASE(XB), .W_BASE(WB), .P_BASE(PB)) dut (
    .clk(clk), .reset(reset), .start(start), .num_x(num_x), .L0_full(L0_full),
    .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done));

  always #5 clk = ~clk;

  typedef struct { int loads; int execs; int len; } tile_t;
  int    exp_xrd[$];
  int    exp_pw[$];
  int    exp_pr[$];
  tile_t exp_tile[$];
  int    checks = 0, fails = 0, done_cnt = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic miss(input string name);
    checks++;
    fails++;
    $display("FAIL %s: event with no expectation queued at %0t", name, $time);
  endtask

  // Reference model: tile length with no stalls and ofifo_valid always high.
  function automatic int tile_len(input int n);
    int l;
    if (n == 0) return 1 + (COL + 1) + COL + (ROW + COL) + 1;
    l = 1 + (COL + 1) + COL + (ROW + COL) + (n + 1) + n + (n + 1) + 1;
`ifdef CORELET_CTRL_ACC_EN
    l += n + 1;
`endif
    return l;
  endfunction

  task automatic push_tile(input int n, input bit chk_len, input int extra);
    tile_t t;
    for (int k = 0; k < COL; k++) exp_xrd.push_back((WB + k) % AMOD);
    for (int k = 0; k < n; k++) begin
      exp_xrd.push_back((XB + k) % AMOD);
      exp_pw.push_back((PB + k) % AMOD);
`ifdef CORELET_CTRL_ACC_EN
      exp_pr.push_back((PB + k) % AMOD);
`endif
    end
    t.loads = COL;
    t.execs = n;
    t.len   = chk_len ? tile_len(n) + extra : -1;
    exp_tile.push_back(t);
  endtask

  task automatic start_tile(input int n);
    @(posedge clk); #1 start = 1'b1; num_x = ABW'(n);
    @(posedge clk); #1 start = 1'b0; num_x = ABW'($urandom);
  endtask

  task automatic wait_done(input int limit);
    int base;
    bit got;
    base = done_cnt;
    got  = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      if (done_cnt != base) begin got = 1'b1; break; end
    end
    checks++;
    if (!got) begin
      fails++;
      $display("FAIL tile_timeout: no done within %0d cycles", limit);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // input samplers and random input drivers
  initial forever begin
    @(posedge clk);
    full_s = L0_full;
    ofv_s  = ofifo_valid;
    #1;
    full_rnd = ($urandom_range(0, 3) == 0);
    ofv_rnd  = 1'(($urandom_range(0, 1)));
  end

  // monitor
  initial begin
    logic  prev_xrd, prev_ofrd, prev_pr, post_done;
    logic  pwr, prd;
    int    bl, nload, nexec;
    tile_t t;
    prev_xrd = 0; prev_ofrd = 0; prev_pr = 0; post_done = 0;
    bl = 0; nload = 0; nexec = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_xrd = 0; prev_ofrd = 0; prev_pr = 0; post_done = 0;
        bl = 0; nload = 0; nexec = 0;
        continue;
      end
      if (post_done) begin
        chk("done_one_cycle", {done, busy}, 2'b00);
        post_done = 0;
      end
      chk("static_bits", {inst[18], inst[5], inst[4]}, 3'b100);
      if (busy) bl++;
      if (full_s) chk("no_read_while_full", inst[19], 1);
      if (!inst[19]) begin
        if (exp_xrd.size() == 0) miss("xmem_read");
        else chk("xmem_addr", inst[17:7], exp_xrd.pop_front());
      end
      if (inst[2] || prev_xrd) chk("l0_wr_after_read", inst[2], prev_xrd);
      prev_xrd = !inst[19];
      if (inst[3] || inst[1] || inst[0]) chk("l0_rd_with_load_exec", inst[3], inst[1] | inst[0]);
      if (inst[6]) chk("ofifo_rd_needs_valid", ofv_s, 1);
      pwr = !inst[32] && !inst[31];
      prd = !inst[32] && inst[31];
      if (pwr || prev_ofrd) chk("pmem_wr_after_ofifo_rd", pwr, prev_ofrd);
      prev_ofrd = inst[6];
      if (pwr) begin
        if (exp_pw.size() == 0) miss("pmem_write");
        else chk("pmem_wr_addr", inst[30:20], exp_pw.pop_front());
      end
      if (prd) begin
        if (exp_pr.size() == 0) miss("pmem_read");
        else chk("pmem_rd_addr", inst[30:20], exp_pr.pop_front());
      end
      if (inst[33] || prev_pr) chk("acc_after_pmem_rd", inst[33], prev_pr);
      prev_pr = prd;
      if (inst[0]) nload++;
      if (inst[1]) nexec++;
      if (done) begin
        if (exp_tile.size() == 0) miss("done");
        else begin
          t = exp_tile.pop_front();
          chk("load_cycles", nload, t.loads);
          chk("execute_cycles", nexec, t.execs);
          if (t.len >= 0) chk("tile_length", bl, t.len);
        end
        done_cnt++;
        post_done = 1;
        bl = 0; nload = 0; nexec = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int n;
    reset = 1'b1; start = 1'b1; num_x = 11'd5;
    repeat (3) begin
      @(negedge clk);
      chk("reset_inst", inst, IDLE_INST);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
    end
    @(posedge clk); #1 reset = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // nominal tile, then the empty-activation tile
    push_tile(4, 1, 0); start_tile(4); wait_done(200);
    push_tile(0, 1, 0); start_tile(0); wait_done(200);

    // start during WPAUSE must be ignored
    push_tile(3, 1, 0); start_tile(3);
    repeat (20) @(posedge clk);
    #1 start = 1'b1; num_x = 11'd7;
    @(posedge clk); #1 start = 1'b0;
    wait_done(200);

    // three-cycle L0_full stall during XLOAD
    push_tile(6, 1, 3); start_tile(6);
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!inst[19] && inst[17:7] == 11'(XB + 1)) begin got = 1; break; end
    end
    if (!got) begin checks++; fails++; $display("FAIL stall_setup: second activation read not seen"); end
    @(posedge clk); #1 full_dir = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_cen_xmem", inst[19], 1);
      chk("stall_a_xmem", inst[17:7], (XB + 3) % AMOD);
      chk("stall_l0_wr", inst[2], (i == 0) ? 1 : 0);
    end
    full_dir = 1'b0;
    wait_done(200);

    // reset mid-XEXEC, then a clean restart
    push_tile(4, 0, 0); start_tile(4);
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (inst[1]) begin got = 1; break; end
    end
    if (!got) begin checks++; fails++; $display("FAIL midreset_setup: execute not seen"); end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("midreset_inst", inst, IDLE_INST);
    chk("midreset_busy", busy, 0);
    exp_xrd.delete(); exp_pw.delete(); exp_pr.delete(); exp_tile.delete();
    @(posedge clk); #1 reset = 1'b0;
    push_tile(3, 1, 0); start_tile(3); wait_done(200);

    push_tile(2, 1, 0); start_tile(2); wait_done(200);

    // randomized tiles with random stalls and OFIFO gaps
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(0, 12);
      stall_rand = 1'b1; ofifo_rand = 1'b1;
      push_tile(n, 0, 0); start_tile(n); wait_done(1000);
      stall_rand = 1'b0; ofifo_rand = 1'b0;
    end

    chk("xrd_queue_empty", exp_xrd.size(), 0);
    chk("pw_queue_empty", exp_pw.size(), 0);
    chk("pr_queue_empty", exp_pr.size(), 0);
    chk("tile_queue_empty", exp_tile.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
